// File: rtl/debounce_filter.sv
// Glitch filter: o commits to a new level only after the input has disagreed with it
// for STABLE_CYCLES consecutive aclk edges. DEBOUNCE_FILTER_INPUT_SYNC_EN adds a 2-flop input synchronizer.
module debounce_filter #(
    parameter int   CNT_W         = 16,
    parameter int   STABLE_CYCLES = 1000,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic s,
    output logic o,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_stable_cycles
        $error("debounce_filter: STABLE_CYCLES out of range for CNT_W");
    end

    typedef enum logic {STABLE, CHECK} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             s_f;
    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_FILTER_INPUT_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    // Synchronizer stage: s may be fully asynchronous to aclk
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_p0 <= RESET_LEVEL;
            sync_p1 <= RESET_LEVEL;
        end else begin
            sync_p0 <= s;
            sync_p1 <= sync_p0;
        end
    end

    assign s_f = sync_p1;
`else
    assign s_f = s;
`endif

    // Filter stage: cnt holds the number of consecutive mismatches already seen
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= STABLE;
            cnt   <= '0;
            o     <= RESET_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE: begin
                    if (s_f != o) begin
                        if (STABLE_CYCLES == 1) begin
                            o    <= ~o;
                            rise <= ~o;
                            fall <= o;
                            cnt  <= '0;
                            busy <= 1'b0;
                        end else begin
                            state <= CHECK;
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                CHECK: begin
                    if (s_f == o) begin
                        state <= STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == LAST_CNT) begin
                        o     <= ~o;
                        rise  <= ~o;
                        fall  <= o;
                        state <= STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: one instance with STABLE_CYCLES=4, one with STABLE_CYCLES=1.
module tb_debounce_filter;

`ifdef DEBOUNCE_FILTER_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic aclk;
    logic aresetn;
    logic s4, o4, rise4, fall4, busy4;
    logic s1, o1, rise1, fall1, busy1;

    int n_cmp = 0;
    int n_err = 0;
    int rc4 = 0, fc4 = 0, rc1 = 0, fc1 = 0, both4 = 0;

    debounce_filter #(.CNT_W(4), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .s(s4),
        .o(o4), .rise(rise4), .fall(fall4), .busy(busy4)
    );

    debounce_filter #(.CNT_W(4), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .s(s1),
        .o(o1), .rise(rise1), .fall(fall1), .busy(busy1)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Pulse counters sampled just after each active edge
    always @(posedge aclk) begin
        #1;
        if (rise4) rc4++;
        if (fall4) fc4++;
        if (rise4 && fall4) both4++;
        if (rise1) rc1++;
        if (fall1) fc1++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s4 = 1'b1;
        s1 = 1'b1;
        step(3);
        chk("rst_o4", o4, 0);
        chk("rst_rise4", rise4, 0);
        chk("rst_fall4", fall4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_o1", o1, 0);
        chk("rst_rise1", rise1, 0);

        s4 = 1'b0;
        s1 = 1'b0;
        aresetn = 1'b1;
        step(20);
        chk("idle_o4", o4, 0);
        chk("idle_busy4", busy4, 0);
        chk("idle_pulses4", rc4 + fc4, 0);
        chk("idle_pulses1", rc1 + fc1, 0);

        // Rise qualification
        s4 = 1'b1;
        step(LAT);
        step(1); chk("rq_busy_e1", busy4, 1); chk("rq_o_e1", o4, 0);
        step(1); chk("rq_busy_e2", busy4, 1);
        step(1); chk("rq_busy_e3", busy4, 1); chk("rq_o_e3", o4, 0);
        step(1); chk("rq_o_e4", o4, 1); chk("rq_rise_e4", rise4, 1); chk("rq_busy_e4", busy4, 0);
        step(1); chk("rq_rise_e5", rise4, 0); chk("rq_o_e5", o4, 1);
        chk("rq_rise_cnt", rc4, 1);

        // Fall qualification
        s4 = 1'b0;
        step(LAT);
        step(3); chk("fq_o_e3", o4, 1); chk("fq_busy_e3", busy4, 1);
        step(1); chk("fq_o_e4", o4, 0); chk("fq_fall_e4", fall4, 1); chk("fq_rise_e4", rise4, 0);
        step(1); chk("fq_fall_e5", fall4, 0);
        chk("fq_fall_cnt", fc4, 1);
        chk("fq_rise_cnt", rc4, 1);

        // Glitch of three sampled cycles
        s4 = 1'b1;
        step(3);
        s4 = 1'b0;
        step(LAT);
        chk("gl_busy", busy4, 1);
        chk("gl_o", o4, 0);
        step(1);
        chk("gl_busy_drop", busy4, 0);
        step(5);
        chk("gl_o_end", o4, 0);
        chk("gl_rise_cnt", rc4, 1);

        // Input toggling every cycle never commits
        for (int i = 0; i < 12; i++) begin
            s4 = ~s4;
            step(1);
        end
        s4 = 1'b0;
        step(LAT + 2);
        chk("tg_o", o4, 0);
        chk("tg_rise_cnt", rc4, 1);
        chk("tg_fall_cnt", fc4, 1);

        // Reset in the middle of a qualification
        s4 = 1'b1;
        step(LAT + 2);
        chk("rm_busy_pre", busy4, 1);
        aresetn = 1'b0;
        #2;
        chk("rm_busy_async", busy4, 0);
        chk("rm_o_async", o4, 0);
        step(1);
        aresetn = 1'b1;
        step(LAT + 3);
        chk("rm_busy_e3", busy4, 1);
        chk("rm_o_e3", o4, 0);
        step(1);
        chk("rm_o_e4", o4, 1);
        chk("rm_rise_e4", rise4, 1);
        chk("rm_rise_cnt", rc4, 2);

        // Back-to-back reverse change
        s4 = 1'b0;
        step(LAT + 3);
        chk("bb_busy", busy4, 1);
        chk("bb_o_pre", o4, 1);
        step(1);
        chk("bb_o", o4, 0);
        chk("bb_fall", fall4, 1);
        chk("bb_fall_cnt", fc4, 2);
        chk("never_both4", both4, 0);

        // STABLE_CYCLES=1 instance
        s1 = 1'b1;
        step(LAT);
        chk("s1_o_pre", o1, 0);
        step(1);
        chk("s1_o_rise", o1, 1);
        chk("s1_rise", rise1, 1);
        chk("s1_busy", busy1, 0);
        step(1);
        chk("s1_rise_end", rise1, 0);
        s1 = 1'b0;
        step(LAT);
        chk("s1_o_hold", o1, 1);
        step(1);
        chk("s1_o_fall", o1, 0);
        chk("s1_fall", fall1, 1);
        for (int i = 0; i < 6; i++) begin
            s1 = ~s1;
            step(1);
        end
        step(LAT + 1);
        chk("s1_rise_cnt", rc1, 4);
        chk("s1_fall_cnt", fc1, 4);
        chk("s1_o_end", o1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
